// File: rtl/beat_packer_with_control_pkg.sv
// ============================================================================
// Module : beat_packer_with_control_pkg
// Brief  : Shared slice-width, count-width and fill-order definitions for the
//          beat packer family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package beat_packer_with_control_pkg;

    localparam int c_DEF_UNITS = 4;
    localparam int c_DEF_EW    = 32;
    localparam int c_DEF_W     = c_DEF_UNITS * c_DEF_EW;

    localparam bit c_MSB_FIRST = 1'b1;
    localparam bit c_LSB_FIRST = 1'b0;

    function automatic int slice_width(input int units, input int ew);
        return units * ew;
    endfunction

    // Counts up to and including nb, so a full word's beat count fits.
    function automatic int beat_cnt_width(input int nb);
        return $clog2(nb + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/beat_packer_with_control_if.sv
// ============================================================================
// Module : beat_packer_with_control_if
// Brief  : Input beat / output word handshake bundle plus flush control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface beat_packer_with_control_if
    import beat_packer_with_control_pkg::*;
#(
    parameter int W  = c_DEF_W,
    parameter int NB = 2,
    parameter int CW = beat_cnt_width(NB)
) ();

    logic [W-1:0]    in;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [NB*W-1:0] out;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_beats;
    logic            busy;

    // Packer side
    modport slave (
        input  in, in_valid, flush, out_ready,
        output in_ready, out, out_valid, out_beats, busy
    );

    // Source / consumer side
    modport master (
        output in, in_valid, flush, out_ready,
        input  in_ready, out, out_valid, out_beats, busy
    );

endinterface

`default_nettype wire

// File: rtl/beat_packer_with_control_slice_insert.sv
// ============================================================================
// Module : packer_slice_insert
// Brief  : Combinational write of one W-bit beat into a NB-slice word at the
//          slot selected by beat index and fill order.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module packer_slice_insert
    import beat_packer_with_control_pkg::*;
#(
    parameter int W         = c_DEF_W,
    parameter int NB        = 2,
    parameter int CW        = beat_cnt_width(NB),
    parameter bit MSB_FIRST = c_MSB_FIRST
) (
    input  wire logic [NB*W-1:0] i_asm,
    input  wire logic [W-1:0]    i_in,
    input  wire logic [CW-1:0]   i_idx,
    output wire logic [NB*W-1:0] o_asm
);

    generate
        for (genvar j = 0; j < NB; j++) begin : g_slice
            // Beat number that lands in slice j for the chosen order.
            localparam int c_BEAT = MSB_FIRST ? (NB - 1 - j) : j;
            assign o_asm[j*W +: W] = (i_idx == CW'(c_BEAT)) ? i_in : i_asm[j*W +: W];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/beat_packer_with_control.sv
// ============================================================================
// Module : beat_packer_with_control
// Brief  : N-beat packer with valid/ready on both sides, backpressure and
//          partial-word flush reporting the filled beat count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module beat_packer_with_control
    import beat_packer_with_control_pkg::*;
#(
    parameter int NO_OF_UNITS   = c_DEF_UNITS,
    parameter int ELEMENT_WIDTH = c_DEF_EW,
    parameter int NO_OF_BEATS   = 2,
    parameter bit MSB_FIRST     = c_MSB_FIRST
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    beat_packer_with_control_if.slave   bus
);

    localparam int c_W  = slice_width(NO_OF_UNITS, ELEMENT_WIDTH);
    localparam int c_NB = NO_OF_BEATS;
    localparam int c_CW = beat_cnt_width(NO_OF_BEATS);

    logic [c_NB*c_W-1:0] r_asm;
    logic [c_CW-1:0]     r_cnt;
    logic [c_NB*c_W-1:0] r_out;
    logic                r_out_valid;
    logic [c_CW-1:0]     r_out_beats;

    logic [c_NB*c_W-1:0] w_ins_asm;
    logic                w_out_free;
    logic                w_last;
    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_flush_go;
    logic                w_load_full;

    packer_slice_insert #(
        .W         (c_W),
        .NB        (c_NB),
        .CW        (c_CW),
        .MSB_FIRST (MSB_FIRST)
    ) u_insert (
        .i_asm (r_asm),
        .i_in  (bus.in),
        .i_idx (r_cnt),
        .o_asm (w_ins_asm)
    );

    assign w_out_free  = !r_out_valid || bus.out_ready;
    assign w_last      = (r_cnt == c_CW'(c_NB - 1));
    // The last beat may only be taken when the output register can accept it.
    assign w_in_ready  = !bus.flush && !(w_last && !w_out_free);
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_out_fire  = r_out_valid && bus.out_ready;
    assign w_load_full = w_in_fire && w_last;
    assign w_flush_go  = bus.flush && (r_cnt != '0) && w_out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm <= '0;
            r_cnt <= '0;
        end else if (w_load_full || w_flush_go) begin
            r_asm <= '0;
            r_cnt <= '0;
        end else if (w_in_fire) begin
            r_asm <= w_ins_asm;
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    // A new word always wins over retiring the old one in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_beats <= '0;
        end else if (w_load_full) begin
            r_out       <= w_ins_asm;
            r_out_valid <= 1'b1;
            r_out_beats <= c_CW'(c_NB);
        end else if (w_flush_go) begin
            r_out       <= r_asm;
            r_out_valid <= 1'b1;
            r_out_beats <= r_cnt;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_beats = r_out_beats;
    assign bus.busy      = (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_beat_packer_with_control.sv
// ============================================================================
// Module : tb_beat_packer_with_control
// Brief  : Directed bench for the beat packer: two-beat, four-beat flush and
//          three-beat LSB-first instances sharing one clock and reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_beat_packer_with_control;

    localparam int c_W = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    beat_packer_with_control_if #(.W(c_W), .NB(2), .CW(2)) bus0 ();
    beat_packer_with_control_if #(.W(c_W), .NB(4), .CW(3)) bus1 ();
    beat_packer_with_control_if #(.W(c_W), .NB(3), .CW(2)) bus2 ();

    beat_packer_with_control #(.NO_OF_UNITS(4), .ELEMENT_WIDTH(32), .NO_OF_BEATS(2), .MSB_FIRST(1'b1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    beat_packer_with_control #(.NO_OF_UNITS(4), .ELEMENT_WIDTH(32), .NO_OF_BEATS(4), .MSB_FIRST(1'b1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    beat_packer_with_control #(.NO_OF_UNITS(4), .ELEMENT_WIDTH(32), .NO_OF_BEATS(3), .MSB_FIRST(1'b0))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    localparam logic [c_W-1:0] c_A = {32{4'h1}};
    localparam logic [c_W-1:0] c_B = {32{4'h2}};
    localparam logic [c_W-1:0] c_C = {32{4'h3}};
    localparam logic [c_W-1:0] c_D = {32{4'h4}};
    localparam logic [c_W-1:0] c_Z = '0;

    typedef struct {
        logic [c_W-1:0]   d;
        bit               v;
        bit               fl;
        bit               ordy;
        bit               e_ir;
        bit               e_ov;
        bit               e_chk;
        logic [2*c_W-1:0] e_out;
        logic [1:0]       e_beats;
        bit               e_busy;
    } vec_t;

    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic [c_W-1:0] d, bit v, bit fl, bit ordy, bit e_ir,
                                bit e_ov, bit e_chk, logic [2*c_W-1:0] e_out,
                                logic [1:0] e_beats, bit e_busy);
        vec_t r;
        r.d = d; r.v = v; r.fl = fl; r.ordy = ordy; r.e_ir = e_ir; r.e_ov = e_ov;
        r.e_chk = e_chk; r.e_out = e_out; r.e_beats = e_beats; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [c_W-1:0] prev;
        logic [c_W-1:0] cur;

        // Two-beat basic pack, then backpressure A,B,C,D.
        vecs[0] = mk(c_A, 1, 0, 1, 1, 0, 0, '0,         2'd0, 1);
        vecs[1] = mk(c_B, 1, 0, 1, 1, 1, 1, {c_A, c_B}, 2'd2, 0);
        vecs[2] = mk(c_Z, 0, 0, 1, 1, 0, 0, '0,         2'd0, 0);
        vecs[3] = mk(c_A, 1, 0, 0, 1, 0, 0, '0,         2'd0, 1);
        vecs[4] = mk(c_B, 1, 0, 0, 1, 1, 1, {c_A, c_B}, 2'd2, 0);
        vecs[5] = mk(c_C, 1, 0, 0, 1, 1, 1, {c_A, c_B}, 2'd2, 1);
        vecs[6] = mk(c_D, 1, 0, 0, 0, 1, 1, {c_A, c_B}, 2'd2, 1);
        vecs[7] = mk(c_D, 1, 0, 1, 1, 1, 1, {c_C, c_D}, 2'd2, 0);
        vecs[8] = mk(c_Z, 0, 0, 1, 1, 0, 0, '0,         2'd0, 0);

        bus0.in = '0; bus0.in_valid = 0; bus0.flush = 0; bus0.out_ready = 1;
        bus1.in = '0; bus1.in_valid = 0; bus1.flush = 0; bus1.out_ready = 1;
        bus2.in = '0; bus2.in_valid = 0; bus2.flush = 0; bus2.out_ready = 1;

        #12;
        chk("reset_out",       512'(bus0.out),       '0);
        chk("reset_out_valid", 512'(bus0.out_valid), '0);
        chk("reset_out_beats", 512'(bus0.out_beats), '0);
        chk("reset_busy",      512'(bus0.busy),      '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            bus0.in        = vecs[i].d;
            bus0.in_valid  = vecs[i].v;
            bus0.flush     = vecs[i].fl;
            bus0.out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 512'(bus0.in_ready), 512'(vecs[i].e_ir));
            tick();
            chk($sformatf("v%0d_out_valid", i), 512'(bus0.out_valid), 512'(vecs[i].e_ov));
            if (vecs[i].e_chk) begin
                chk($sformatf("v%0d_out", i),       512'(bus0.out),       512'(vecs[i].e_out));
                chk($sformatf("v%0d_out_beats", i), 512'(bus0.out_beats), 512'(vecs[i].e_beats));
            end
            chk($sformatf("v%0d_busy", i), 512'(bus0.busy), 512'(vecs[i].e_busy));
        end
        bus0.in_valid = 0;

        // Async reset mid-word: one beat in, reset between edges.
        bus0.in = c_A; bus0.in_valid = 1; bus0.out_ready = 1;
        tick();
        bus0.in_valid = 0;
        chk("rst_pre_busy", 512'(bus0.busy), 512'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_busy",      512'(bus0.busy),      '0);
        chk("rst_out_valid", 512'(bus0.out_valid), '0);
        chk("rst_out",       512'(bus0.out),       '0);
        #1;
        rst_n = 1'b1;
        tick();
        bus0.in = c_A; bus0.in_valid = 1;
        tick();
        bus0.in = c_B;
        tick();
        bus0.in_valid = 0;
        chk("rst_post_valid", 512'(bus0.out_valid), 512'(1));
        chk("rst_post_out",   512'(bus0.out),       512'({c_A, c_B}));
        tick();

        // Continuous stream of 8 beats.
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            cur = {4{32'(k + 16)}};
            bus0.in = cur; bus0.in_valid = 1; bus0.out_ready = 1;
            #1;
            chk($sformatf("s%0d_in_ready", k), 512'(bus0.in_ready), 512'(1));
            tick();
            chk($sformatf("s%0d_out_valid", k), 512'(bus0.out_valid), 512'(k % 2));
            if (k % 2 == 1)
                chk($sformatf("s%0d_out", k), 512'(bus0.out), 512'({prev, cur}));
            prev = cur;
        end
        bus0.in_valid = 0;

        // Four-beat flush of a partial word.
        bus1.in = c_A; bus1.in_valid = 1; bus1.out_ready = 1;
        tick();
        bus1.in_valid = 0;
        chk("f_busy1", 512'(bus1.busy), 512'(1));
        bus1.flush = 1;
        #1;
        chk("f_in_ready", 512'(bus1.in_ready), '0);
        tick();
        chk("f_out_valid", 512'(bus1.out_valid), 512'(1));
        chk("f_out",       512'(bus1.out),       512'({c_A, c_Z, c_Z, c_Z}));
        chk("f_out_beats", 512'(bus1.out_beats), 512'(1));
        chk("f_busy0",     512'(bus1.busy),      '0);
        tick();
        chk("f_retire_valid", 512'(bus1.out_valid), '0);
        chk("f_in_ready2",    512'(bus1.in_ready),  '0);
        bus1.flush = 0;
        tick();
        bus1.flush = 1;
        tick();
        chk("f_empty_valid", 512'(bus1.out_valid), '0);
        chk("f_empty_busy",  512'(bus1.busy),      '0);
        bus1.flush = 0;

        // Flush waits while the output register is still occupied.
        bus1.out_ready = 0; bus1.in_valid = 1;
        bus1.in = c_A; tick();
        bus1.in = c_B; tick();
        bus1.in = c_C; tick();
        bus1.in = c_D; tick();
        chk("fw_full_out",   512'(bus1.out),       512'({c_A, c_B, c_C, c_D}));
        chk("fw_full_beats", 512'(bus1.out_beats), 512'(4));
        bus1.in = c_B; tick();
        bus1.in_valid = 0;
        bus1.flush = 1;
        tick();
        chk("fw_hold_out",  512'(bus1.out),  512'({c_A, c_B, c_C, c_D}));
        chk("fw_hold_busy", 512'(bus1.busy), 512'(1));
        bus1.out_ready = 1;
        tick();
        chk("fw_out",       512'(bus1.out),       512'({c_B, c_Z, c_Z, c_Z}));
        chk("fw_out_beats", 512'(bus1.out_beats), 512'(1));
        chk("fw_valid",     512'(bus1.out_valid), 512'(1));
        bus1.flush = 0;
        tick();

        // Three-beat LSB-first.
        bus2.in_valid = 1; bus2.out_ready = 1;
        bus2.in = c_A; tick();
        bus2.in = c_B; tick();
        bus2.in = c_C; tick();
        bus2.in_valid = 0;
        chk("lsb_valid",     512'(bus2.out_valid), 512'(1));
        chk("lsb_out",       512'(bus2.out),       512'({c_C, c_B, c_A}));
        chk("lsb_out_beats", 512'(bus2.out_beats), 512'(3));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
